// File: rtl/handshake_data_to_ctrl_if.sv
// Bundle for the data-to-control token converter.
// slave  : converter side (takes data tokens, offers ctrl tokens)
// master : environment side (offers data tokens, takes ctrl tokens)
interface handshake_data_to_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic                  ctrl_valid;
    logic                  ctrl_ready;
    logic [CNT_W-1:0]      occupancy;
    logic                  err;
    logic [7:0]            err_count;

    modport slave (
        input  ins, ins_valid, ctrl_ready,
        output ins_ready, ctrl_valid, occupancy, err, err_count
    );

    modport master (
        output ins, ins_valid, ctrl_ready,
        input  ins_ready, ctrl_valid, occupancy, err, err_count
    );
endinterface

// File: rtl/handshake_data_to_ctrl.sv
// Data handshake -> dataless control token converter.
// Each accepted data token becomes one ctrl token. Tokens are held as a count
// (0..DEPTH), so both sides see ready/valid derived only from the count and
// there is no combinational path between the two channels.
// Optional payload check: define HANDSHAKE_DATA_TO_CTRL_CHECK_EN to compare
// each accepted payload against EXPECTED and report mismatches on err /
// err_count. Without it err and err_count are constant zero.
module handshake_data_to_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] EXPECTED   = 32'd1
) (
    input  logic                       clk,
    input  logic                       rst,
    handshake_data_to_ctrl_if.slave    bus
);
    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    // Handshake flags come from the count alone, never from the other side.
    assign bus.ins_ready  = (cnt_q != FULL);
    assign bus.ctrl_valid = (cnt_q != '0);
    assign bus.occupancy  = cnt_q;

    assign push = bus.ins_valid  & bus.ins_ready;
    assign pop  = bus.ctrl_valid & bus.ctrl_ready;

    // Next count: simultaneous push and pop cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + ONE;
        else if (pop && !push)
            cnt_d = cnt_q - ONE;
    end

    // Token count register; reset drops any tokens in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

`ifdef HANDSHAKE_DATA_TO_CTRL_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] EXP_V = DATA_WIDTH'(EXPECTED);

    logic       err_q;
    logic [7:0] err_cnt_q;
    logic       mismatch;

    assign mismatch = push && (bus.ins != EXP_V);

    // Sticky error flag and saturating mismatch counter; never gates handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else if (mismatch) begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err       = err_q;
    assign bus.err_count = err_cnt_q;
`else
    // Payload and EXPECTED are intentionally ignored in this build.
    logic unused_payload;
    assign unused_payload = ^{bus.ins, EXPECTED};

    assign bus.err       = 1'b0;
    assign bus.err_count = 8'h00;
`endif
endmodule

// File: tb/tb_handshake_data_to_ctrl.sv
// Bench for handshake_data_to_ctrl: vector table, hand sequences for fill,
// streaming and reset, and a random run against a token-count model.
module tb_handshake_data_to_ctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    handshake_data_to_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    handshake_data_to_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .EXPECTED(32'd1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // observations from the last cycle
    logic       o_ir, o_cv, o_push, o_pop, o_err;
    logic [1:0] o_occ;
    logic [7:0] o_ec;

    typedef struct {
        logic        r, iv, cr;
        logic [31:0] d;
        logic        ir, cv;
        logic [1:0]  occ;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic ok, input string detail);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and sample the outputs 1 ns later.
    task automatic cyc(input logic r, input logic iv, input logic cr, input logic [31:0] d);
        @(negedge clk);
        rst = r; bus.ins_valid = iv; bus.ctrl_ready = cr; bus.ins = d;
        #1;
        o_ir = bus.ins_ready; o_cv = bus.ctrl_valid; o_occ = bus.occupancy;
        o_err = bus.err; o_ec = bus.err_count;
        o_push = iv & o_ir & ~r;
        o_pop  = o_cv & cr & ~r;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int np, nq, m, tin, tout;
    logic prev_hold;

    initial begin
        bus.ins = '0; bus.ins_valid = 1'b0; bus.ctrl_ready = 1'b0;

        //            r  iv cr d      ir cv occ
        tbl[0]  = '{1'b0,1'b1,1'b0,32'h1, 1'b1,1'b0,2'd0}; // empty, push
        tbl[1]  = '{1'b0,1'b1,1'b0,32'h1, 1'b1,1'b1,2'd1}; // push -> full
        tbl[2]  = '{1'b0,1'b1,1'b0,32'h1, 1'b0,1'b1,2'd2}; // full, stalled
        tbl[3]  = '{1'b0,1'b1,1'b0,32'h1, 1'b0,1'b1,2'd2};
        tbl[4]  = '{1'b0,1'b1,1'b1,32'h1, 1'b0,1'b1,2'd2}; // full: pop only
        tbl[5]  = '{1'b0,1'b1,1'b1,32'h1, 1'b1,1'b1,2'd1}; // push+pop, stays 1
        tbl[6]  = '{1'b0,1'b0,1'b1,32'h0, 1'b1,1'b1,2'd1}; // pop -> empty
        tbl[7]  = '{1'b0,1'b0,1'b1,32'h0, 1'b1,1'b0,2'd0}; // empty, idle
        tbl[8]  = '{1'b0,1'b1,1'b1,32'h1, 1'b1,1'b0,2'd0}; // empty: push only
        tbl[9]  = '{1'b0,1'b1,1'b0,32'h1, 1'b1,1'b1,2'd1}; // push -> 2
        tbl[10] = '{1'b1,1'b1,1'b0,32'h1, 1'b1,1'b0,2'd0}; // async reset at cnt=2
        tbl[11] = '{1'b0,1'b0,1'b1,32'h0, 1'b1,1'b0,2'd0}; // no stray token

        // reset state, checked while rst is held
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("reset_state", o_ir == 1'b1 && o_cv == 1'b0 && o_occ == 2'd0 && o_err == 1'b0 && o_ec == 8'h00,
            $sformatf("got ir=%b cv=%b occ=%0d err=%b ec=%0d want 1 0 0 0 0", o_ir, o_cv, o_occ, o_err, o_ec));
        do_reset();

        // vector table
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].r, tbl[i].iv, tbl[i].cr, tbl[i].d);
            chk($sformatf("vec%0d", i), o_ir == tbl[i].ir && o_cv == tbl[i].cv && o_occ == tbl[i].occ,
                $sformatf("got ir=%b cv=%b occ=%0d want ir=%b cv=%b occ=%0d",
                          o_ir, o_cv, o_occ, tbl[i].ir, tbl[i].cv, tbl[i].occ));
        end

        // fill: 4 cycles with ctrl stalled -> exactly DEPTH pushes
        do_reset();
        np = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'd1);
            if (o_push) np++;
        end
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk("fill_pushes", np == DEPTH, $sformatf("got %0d pushes want %0d", np, DEPTH));
        chk("fill_state", o_occ == 2'd2 && o_ir == 1'b0,
            $sformatf("got occ=%0d ir=%b want occ=2 ir=0", o_occ, o_ir));

        // streaming: 100 cycles both sides ready
        do_reset();
        np = 0; nq = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 32'd1);
            if (o_push) np++;
            if (o_pop)  nq++;
            if (i > 0)
                chk("stream_occ", o_occ == 2'd1, $sformatf("cycle %0d got occ=%0d want 1", i, o_occ));
        end
        chk("stream_counts", np == 100 && nq == 99,
            $sformatf("got push=%0d pop=%0d want 100 99", np, nq));

        // random stall against a token-count model
        do_reset();
        m = 0; tin = 0; tout = 0; prev_hold = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            logic iv, cr, mr, mv;
            iv = 1'($urandom_range(0, 1));
            cr = 1'($urandom_range(0, 1));
            cyc(1'b0, iv, cr, $urandom);
            mr = (m < DEPTH);
            mv = (m > 0);
            chk("rand_model", o_ir == mr && o_cv == mv && int'(o_occ) == m,
                $sformatf("cycle %0d got ir=%b cv=%b occ=%0d want ir=%b cv=%b occ=%0d",
                          i, o_ir, o_cv, o_occ, mr, mv, m));
            if (prev_hold)
                chk("rand_hold", o_cv == 1'b1, $sformatf("cycle %0d ctrl_valid dropped without pop", i));
            prev_hold = mv && !cr;
            if (iv && mr) begin m++; tin++; end
            if (mv && cr) begin m--; tout++; end
        end
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk("rand_balance", tout == tin - int'(o_occ),
            $sformatf("got out=%0d in=%0d occ=%0d", tout, tin, o_occ));

`ifdef HANDSHAKE_DATA_TO_CTRL_CHECK_EN
        // payload check: 1,3,1,0 -> two mismatches, then saturation
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 32'd3);
        chk("chk_err_clean", o_err == 1'b0, $sformatf("got err=%b want 0", o_err));
        cyc(1'b0, 1'b1, 1'b1, 32'd1);
        chk("chk_err_set", o_err == 1'b1, $sformatf("got err=%b want 1", o_err));
        cyc(1'b0, 1'b1, 1'b1, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'd0);
        chk("chk_err_count", o_err == 1'b1 && o_ec == 8'd2, $sformatf("got err=%b ec=%0d want 1 2", o_err, o_ec));
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 1'b1, 32'd7);
        cyc(1'b0, 1'b0, 1'b1, 32'd0);
        chk("chk_saturate", o_ec == 8'hFF, $sformatf("got ec=%0d want 255", o_ec));
`else
        // no check logic: mismatching payloads leave err quiet
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'd3);
        cyc(1'b0, 1'b1, 1'b1, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'd0);
        chk("nochk_err", o_err == 1'b0 && o_ec == 8'h00, $sformatf("got err=%b ec=%0d want 0 0", o_err, o_ec));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
